// File: rtl/hack_pkg.sv
// Shared types for the Hack bus gather/scatter path.
// Word width, way count and way-select tag used by the arbiter and the DMux8Way return path.
package hack_pkg;
    localparam int HACK_WORD_W = 16;
    localparam int MUX_WAYS    = 8;

    typedef logic [2:0]  way_sel_t;
    typedef logic [15:0] word_t;
endpackage

// File: rtl/rr_pick8.sv
// Combinational 8-way round-robin picker; search starts at ptr+1 and wraps.
// Ports: req[7:0], ptr[2:0] in; gnt_any, gnt_idx[2:0] out.
module rr_pick8
    import hack_pkg::*;
(
    input  logic [7:0] req,
    input  way_sel_t   ptr,
    output logic       gnt_any,
    output way_sel_t   gnt_idx
);

    logic [3:0]  sh;
    logic [15:0] dbl;
    logic [7:0]  rot;
    way_sel_t    pos;

    // Rotate so that way ptr+1 lands on bit 0; ptr=7 gives a shift of 8, i.e. no rotation.
    always_comb begin
        sh  = {1'b0, ptr} + 4'd1;
        dbl = {req, req} >> sh;
        rot = dbl[7:0];
    end

    always_comb begin
        gnt_any = 1'b0;
        pos     = '0;
        for (int j = 7; j >= 0; j--) begin
            if (rot[j]) begin
                gnt_any = 1'b1;
                pos     = 3'(j);
            end
        end
    end

    // Rotate back; the 3-bit sum wraps mod 8.
    assign gnt_idx = pos + ptr + 3'd1;

endmodule

// File: rtl/mux8way_arbiter.sv
// Eight-way round-robin gather into one registered 16-bit stream tagged with the source way.
// Ports: clk, reset_n (sync, active-low); in_valid/in_data/in_ready per way;
// out_valid/out_ready/out_data/out_sel. Define MUX8WAY_ARB_LOCK_EN to add in_last/out_last
// and hold the grant on one way until its packet ends.
module mux8way_arbiter
    import hack_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [MUX_WAYS-1:0]           in_valid,
    input  logic [MUX_WAYS*HACK_WORD_W-1:0] in_data,
    output logic [MUX_WAYS-1:0]           in_ready,
`ifdef MUX8WAY_ARB_LOCK_EN
    input  logic [MUX_WAYS-1:0]           in_last,
    output logic                          out_last,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output word_t                         out_data,
    output way_sel_t                      out_sel
);

    way_sel_t    ptr;
    logic [7:0]  req;
    logic        gnt_any;
    way_sel_t    gnt_idx;
    logic        take;
    word_t       sel_data;

`ifdef MUX8WAY_ARB_LOCK_EN
    logic        locked;
    way_sel_t    lock_way;

    // While locked only the owning way may win, even when it is idle.
    always_comb begin
        req = in_valid;
        if (locked)
            req = in_valid & (8'd1 << lock_way);
    end
`else
    always_comb req = in_valid;
`endif

    rr_pick8 u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt_any (gnt_any),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        take     = reset_n && gnt_any && (!out_valid || out_ready);
        in_ready = take ? (8'd1 << gnt_idx) : 8'd0;
        sel_data = in_data[{gnt_idx, 4'b0000} +: HACK_WORD_W];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= 3'd7;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            ptr       <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX8WAY_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            lock_way <= '0;
            out_last <= 1'b0;
        end else if (take) begin
            locked   <= !in_last[gnt_idx];
            lock_way <= gnt_idx;
            out_last <= in_last[gnt_idx];
        end
    end
`endif

endmodule
